// File: rtl/updown_counter.sv
// updown_counter: prescaled up/down counter with synchronous load and a registered terminal-count pulse.
// Define UPDOWN_COUNTER_SAT_EN to saturate at 0/MAX instead of wrapping. Rev 1.0
`default_nettype none

module updown_counter #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned MAX   = 1023,
  parameter int unsigned DIV   = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_up,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_dat,
  output logic [WIDTH-1:0] o_cnt_dat,
  output logic             o_tc
);

  // DIV=1 still needs a 1-bit prescaler; it simply never leaves 0.
  localparam int unsigned        PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]      PRE_LAST = PW'(DIV - 1);
  localparam logic [WIDTH-1:0]   MAX_V    = WIDTH'(MAX);

  logic [PW-1:0]    pre_q, pre_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;

  always_comb begin
    pre_d = pre_q;
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    if (i_load) begin
      cnt_d = (i_load_dat > MAX_V) ? MAX_V : i_load_dat;
      pre_d = '0;
    end else if (i_en) begin
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        if (i_up) begin
          if (cnt_q < MAX_V) begin
            cnt_d = cnt_q + WIDTH'(1);
          end else begin
`ifdef UPDOWN_COUNTER_SAT_EN
            cnt_d = MAX_V;
`else
            cnt_d = '0;
`endif
            tc_d  = 1'b1;
          end
        end else begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
          end else begin
`ifdef UPDOWN_COUNTER_SAT_EN
            cnt_d = '0;
`else
            cnt_d = MAX_V;
`endif
            tc_d  = 1'b1;
          end
        end
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pre_q <= '0;
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign o_cnt_dat = cnt_q;
  assign o_tc      = tc_q;

endmodule

`default_nettype wire

// File: tb/tb_updown_counter.sv
// tb_updown_counter: directed self-checking bench for updown_counter (three parameter sets).
// Expectations follow UPDOWN_COUNTER_SAT_EN when it is defined.
`default_nettype none

module tb_updown_counter;

`ifdef UPDOWN_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // A: WIDTH=10 MAX=1023 DIV=1
  logic       a_rst_n, a_en, a_up, a_load;
  logic [9:0] a_dat, a_cnt;
  logic       a_tc;
  // B: WIDTH=8 MAX=9 DIV=4
  logic       b_rst_n, b_en, b_up, b_load;
  logic [7:0] b_dat, b_cnt;
  logic       b_tc;
  // C: WIDTH=3 MAX=5 DIV=1
  logic       c_rst_n, c_en, c_up, c_load;
  logic [2:0] c_dat, c_cnt;
  logic       c_tc;

  updown_counter #(.WIDTH(10), .MAX(1023), .DIV(1)) dut_a (
    .i_clk(clk), .i_rst_n(a_rst_n), .i_en(a_en), .i_up(a_up), .i_load(a_load),
    .i_load_dat(a_dat), .o_cnt_dat(a_cnt), .o_tc(a_tc));

  updown_counter #(.WIDTH(8), .MAX(9), .DIV(4)) dut_b (
    .i_clk(clk), .i_rst_n(b_rst_n), .i_en(b_en), .i_up(b_up), .i_load(b_load),
    .i_load_dat(b_dat), .o_cnt_dat(b_cnt), .o_tc(b_tc));

  updown_counter #(.WIDTH(3), .MAX(5), .DIV(1)) dut_c (
    .i_clk(clk), .i_rst_n(c_rst_n), .i_en(c_en), .i_up(c_up), .i_load(c_load),
    .i_load_dat(c_dat), .o_cnt_dat(c_cnt), .o_tc(c_tc));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  int exp_a;
  int exp_tc;
  int base;

  initial begin
    a_rst_n = 0; a_en = 0; a_up = 1; a_load = 0; a_dat = '0;
    b_rst_n = 0; b_en = 0; b_up = 1; b_load = 0; b_dat = '0;
    c_rst_n = 0; c_en = 0; c_up = 1; c_load = 0; c_dat = '0;
    tick_n(2);
    check("rst_a_cnt", a_cnt, 0);
    check("rst_a_tc",  a_tc,  0);
    check("rst_b_cnt", b_cnt, 0);
    check("rst_b_tc",  b_tc,  0);

    // A: free-running up count across the 1023 -> 0 wrap
    a_rst_n = 1; a_en = 1;
    exp_a = 0;
    for (int i = 0; i < 1030; i++) begin
      tick();
      if (exp_a == 1023) begin
        exp_a  = SAT ? 1023 : 0;
        exp_tc = 1;
      end else begin
        exp_a  = exp_a + 1;
        exp_tc = 0;
      end
      check("a_cnt", a_cnt, exp_a);
      check("a_tc",  a_tc,  exp_tc);
    end
    a_en = 0;

    // B: DIV=4 up count, one step per 4 enabled edges, 9 -> 0 on edge 40
    b_rst_n = 1; b_en = 1; b_up = 1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (SAT) check("b_div_cnt", b_cnt, ((n / 4) > 9) ? 9 : (n / 4));
      else     check("b_div_cnt", b_cnt, (n / 4) % 10);
      check("b_div_tc", b_tc, (n == 40) ? 1 : 0);
    end
    base = SAT ? 9 : 0;
    // Pause mid-prescale: two edges accumulated, three idle, then two more to step
    tick_n(2);
    check("b_pre2_cnt", b_cnt, base);
    b_en = 0;
    tick_n(3);
    check("b_pause_cnt", b_cnt, base);
    b_en = 1;
    tick();
    check("b_resume1_cnt", b_cnt, base);
    tick();
    check("b_resume2_cnt", b_cnt, SAT ? 9 : 1);

    // B: load 7 then count down through the 0 -> 9 wrap
    b_load = 1; b_dat = 8'd7; b_en = 0;
    tick();
    check("b_load7_cnt", b_cnt, 7);
    check("b_load7_tc",  b_tc,  0);
    b_load = 0; b_up = 0; b_en = 1;
    for (int s = 1; s <= 8; s++) begin
      tick_n(4);
      if (s == 8) check("b_down_cnt", b_cnt, SAT ? 0 : 9);
      else        check("b_down_cnt", b_cnt, 7 - s);
      check("b_down_tc", b_tc, (s == 8) ? 1 : 0);
    end
    b_en = 0;
    tick();
    check("b_down_tc_end", b_tc, 0);
    b_load = 1; b_dat = 8'd200;
    tick();
    check("b_load200_cnt", b_cnt, 9);

    // B: load wins over a pending wrap step and clears the prescaler
    b_load = 0; b_up = 1; b_en = 1;
    tick_n(3);
    check("b_prestep_cnt", b_cnt, 9);
    b_load = 1; b_dat = 8'd3;
    tick();
    check("b_ldstep_cnt", b_cnt, 3);
    check("b_ldstep_tc",  b_tc,  0);
    b_load = 0;
    tick_n(3);
    check("b_ldpre_cnt", b_cnt, 3);
    tick();
    check("b_ldpre_step", b_cnt, 4);

    // B: reset on a pending wrap edge overrides load and step
    b_load = 1; b_dat = 8'd9;
    tick();
    b_load = 0;
    tick_n(3);
    check("b_prerst_cnt", b_cnt, 9);
    b_rst_n = 0; b_load = 1; b_dat = 8'd5;
    tick();
    check("b_rst_cnt", b_cnt, 0);
    check("b_rst_tc",  b_tc,  0);
    b_rst_n = 1; b_load = 0;
    tick_n(3);
    check("b_postrst_cnt", b_cnt, 0);
    tick();
    check("b_postrst_step", b_cnt, 1);
    b_en = 0;

    // C: behaviour at the MAX/0 boundaries, load clamping
    c_rst_n = 1; c_load = 1; c_dat = 3'd7;
    tick();
    check("c_clamp_cnt", c_cnt, 5);
    c_load = 0; c_en = 1; c_up = 1;
    tick();
    check("c_up1_cnt", c_cnt, SAT ? 5 : 0);
    check("c_up1_tc",  c_tc,  1);
    tick();
    check("c_up2_cnt", c_cnt, SAT ? 5 : 1);
    check("c_up2_tc",  c_tc,  SAT ? 1 : 0);
    c_load = 1; c_dat = 3'd0;
    tick();
    check("c_load0_tc", c_tc, 0);
    c_load = 0; c_up = 0;
    tick();
    check("c_dn1_cnt", c_cnt, SAT ? 0 : 5);
    check("c_dn1_tc",  c_tc,  1);
    tick();
    check("c_dn2_cnt", c_cnt, SAT ? 0 : 4);
    check("c_dn2_tc",  c_tc,  SAT ? 1 : 0);
    c_en = 0;
    tick();
    check("c_hold_tc", c_tc, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
